// File: rtl/inv_sbox_builder.sv
// Builds the inverse of the forward chaotic S-box (inv[sbox[i]] = i), then serves registered lookups.
// Optional duplicate-entry detection is compiled in with `define INV_SBOX_CHECK_EN.
module inv_sbox_builder #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          fw_rd_en,
    output logic [DW-1:0] fw_rd_addr,
    input  logic [DW-1:0] fw_rd_data,
    input  logic          lk_en,
    input  logic [DW-1:0] lk_addr,
    output logic [DW-1:0] lk_data,
    output logic          lk_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int N   = 1 << DW;
    localparam int DCW = $clog2(RD_LAT + 1);
    localparam logic [DW:0] LAST = (DW + 1)'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW:0]     cnt_q, cnt_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic            rd_en_q, rd_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   lk_data_q, lk_data_d;
    logic            lk_valid_q, lk_valid_d;

    logic [RD_LAT-1:0] en_pipe_q, en_pipe_d;
    logic [DW-1:0]     addr_pipe_q [RD_LAT];
    logic [DW-1:0]     addr_pipe_d [RD_LAT];

    logic            wr_en;
    logic [DW-1:0]   wr_val;
    logic [DW-1:0]   inv_mem_q [N];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        rd_en_d = rd_en_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + (DW + 1)'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                    rd_en_d = 1'b0;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                // One cycle beyond RD_LAT so the final write has landed before done rises
                if (drain_q == DCW'(RD_LAT)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_pipe_d[0]   = rd_en_q;
        addr_pipe_d[0] = cnt_q[DW-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
            en_pipe_d[i]   = en_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
        wr_en  = en_pipe_q[RD_LAT-1];
        wr_val = addr_pipe_q[RD_LAT-1];
    end

    always_comb begin
        lk_data_d  = lk_en ? inv_mem_q[lk_addr] : lk_data_q;
        lk_valid_d = lk_en & done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lk_data_q  <= '0;
            lk_valid_q <= 1'b0;
            en_pipe_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lk_data_q  <= lk_data_d;
            lk_valid_q <= lk_valid_d;
            en_pipe_q  <= en_pipe_d;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= addr_pipe_d[i];
            end
        end
    end

    // Table contents are deliberately not reset; they are rebuilt in full on every start
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inv_mem_q[fw_rd_data] <= wr_val;
        end
    end

`ifdef INV_SBOX_CHECK_EN
    logic          accept;
    logic [N-1:0]  seen_q, seen_d;
    logic          err_q, err_d;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        seen_d = seen_q;
        err_d  = err_q;
        if (accept) begin
            seen_d = '0;
            err_d  = 1'b0;
        end else if (wr_en) begin
            if (seen_q[fw_rd_data]) begin
                err_d = 1'b1;
            end
            seen_d[fw_rd_data] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_q <= '0;
            err_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign fw_rd_en   = rd_en_q;
    assign fw_rd_addr = cnt_q[DW-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign lk_data    = lk_data_q;
    assign lk_valid   = lk_valid_q;

endmodule

// File: tb/tb_inv_sbox_builder.sv
// Directed testbench for inv_sbox_builder: forward S-box model with one-cycle read latency,
// hand-computed lookups cross-checked against a locally computed inverse.
module tb_inv_sbox_builder;

    logic       clk;
    logic       rst;
    logic       start;
    logic       fw_rd_en;
    logic [7:0] fw_rd_addr;
    logic [7:0] fw_rd_data;
    logic       lk_en;
    logic [7:0] lk_addr;
    logic [7:0] lk_data;
    logic       lk_valid;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] sbox      [256];
    logic [7:0] model_inv [256];

    int passed;
    int total;
    int cycles;
    logic exp_dup_err;

    inv_sbox_builder #(.DW(8), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fw_rd_en   (fw_rd_en),
        .fw_rd_addr (fw_rd_addr),
        .fw_rd_data (fw_rd_data),
        .lk_en      (lk_en),
        .lk_addr    (lk_addr),
        .lk_data    (lk_data),
        .lk_valid   (lk_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward S-box store: data returns one cycle after the read strobe
    initial fw_rd_data = 8'h00;
    always @(posedge clk) begin
        if (fw_rd_en) fw_rd_data <= sbox[fw_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic build_model();
        for (int i = 0; i < 256; i++) model_inv[sbox[i]] = 8'(i);
    endtask

    // Pulse start, optionally inject a second start and a busy-time lookup, then wait for done
    task automatic apply_stimulus(input int second_at, input int probe_at, input logic exp_err);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_after_start", busy, 1);
        check_output("done_after_start", done, 0);
        check_output("err_after_start", err, 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 400) begin
            if (cycles == second_at) start = 1'b1;
            if (cycles == probe_at) begin
                lk_en   = 1'b1;
                lk_addr = 8'h10;
            end
            tick();
            cycles++;
            start = 1'b0;
            if (cycles == probe_at + 1) begin
                lk_en = 1'b0;
                check_output("busy_lookup_valid", lk_valid, 0);
            end
        end
        check_output("done_latency", cycles, 258);
        check_output("busy_at_done", busy, 0);
        check_output("err_at_done", err, exp_err);
    endtask

    task automatic lookup(input logic [7:0] a, input logic [7:0] hand);
        lk_en   = 1'b1;
        lk_addr = a;
        tick();
        lk_en = 1'b0;
        check_output("lk_valid", lk_valid, 1);
        check_output("lk_data", lk_data, hand);
        check_output("lk_model", lk_data, model_inv[a]);
    endtask

    initial begin
        passed = 0;
        total  = 0;
`ifdef INV_SBOX_CHECK_EN
        exp_dup_err = 1'b1;
`else
        exp_dup_err = 1'b0;
`endif
        rst     = 1'b0;
        start   = 1'b0;
        lk_en   = 1'b0;
        lk_addr = 8'h00;
        for (int i = 0; i < 256; i++) sbox[i] = 8'(i);
        tick();
        tick();
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_fw_rd_en", fw_rd_en, 0);
        check_output("rst_fw_rd_addr", fw_rd_addr, 0);
        check_output("rst_lk_valid", lk_valid, 0);
        check_output("rst_lk_data", lk_data, 0);
        check_output("rst_err", err, 0);
        rst = 1'b1;
        tick();

        $display("[TB] identity table");
        build_model();
        apply_stimulus(-10, -10, 1'b0);
        lookup(8'h5A, 8'h5A);
        lookup(8'hFF, 8'hFF);

        $display("[TB] increment table, start on final drain edge");
        for (int i = 0; i < 256; i++) sbox[i] = 8'((i + 1) % 256);
        build_model();
        apply_stimulus(257, -10, 1'b0);
        tick();
        check_output("late_start_ignored_done", done, 1);
        check_output("late_start_ignored_busy", busy, 0);
        lookup(8'h00, 8'hFF);
        lookup(8'h80, 8'h7F);
        lookup(8'hFF, 8'hFE);

        $display("[TB] xor table, start while busy, lookup while busy");
        for (int i = 0; i < 256; i++) sbox[i] = 8'(i) ^ 8'hA5;
        build_model();
        apply_stimulus(50, 20, 1'b0);
        lookup(8'h00, 8'hA5);
        lookup(8'hA5, 8'h00);
        lookup(8'h10, 8'hB5);

        $display("[TB] reset in the middle of a build");
        for (int i = 0; i < 256; i++) sbox[i] = ~8'(i);
        build_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        check_output("midbuild_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_fw_rd_en", fw_rd_en, 0);
        check_output("abort_fw_rd_addr", fw_rd_addr, 0);
        tick();
        rst = 1'b1;
        tick();
        apply_stimulus(-10, -10, 1'b0);
        lookup(8'h00, 8'hFF);
        lookup(8'h37, 8'hC8);

        $display("[TB] duplicate entries");
        for (int i = 0; i < 256; i++) sbox[i] = 8'(i);
        sbox[3] = 8'h10;
        sbox[7] = 8'h10;
        build_model();
        apply_stimulus(-10, -10, exp_dup_err);
        lookup(8'h10, 8'h10);
        lookup(8'h05, 8'h05);

        $display("[TB] valid table clears the flag");
        sbox[3] = 8'h03;
        sbox[7] = 8'h07;
        build_model();
        apply_stimulus(-10, -10, 1'b0);
        lookup(8'h03, 8'h03);
        lookup(8'h07, 8'h07);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
